// File: rtl/leaf_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leaf_stream_pkg
// Description : Shared defaults and width helpers for leaf stream buffers.
//               DEFAULT_PAYLOAD_BITS : width of one stream word
//               DEFAULT_DEPTH_BITS   : log2 of buffer depth
//               count_width()        : width of an occupancy counter that must
//                                      hold 0..2^depth_bits inclusive
// Revision    : 1.0 - initial release
// ============================================================================
package leaf_stream_pkg;

    localparam int DEFAULT_PAYLOAD_BITS = 32;
    localparam int DEFAULT_DEPTH_BITS   = 4;

    // One extra bit so that the "full" value 2^depth_bits is representable.
    function automatic int count_width(input int depth_bits);
        return depth_bits + 1;
    endfunction

endpackage : leaf_stream_pkg
`default_nettype wire

// File: rtl/user_stream_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : user_stream_buffer_mem
// Description : 2^DEPTH_BITS x PAYLOAD_BITS storage, synchronous write and
//               asynchronous read, intended for distributed RAM.
//   clk     in   write clock
//   i_we    in   write enable
//   i_waddr in   write address
//   i_wdata in   write data
//   i_raddr in   read address
//   o_rdata out  read data (combinational from i_raddr)
// Revision    : 1.0 - initial release
// ============================================================================
module user_stream_buffer_mem #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [DEPTH_BITS-1:0]   i_waddr,
    input  logic [PAYLOAD_BITS-1:0] i_wdata,
    input  logic [DEPTH_BITS-1:0]   i_raddr,
    output logic [PAYLOAD_BITS-1:0] o_rdata
);

    localparam int c_depth = 1 << DEPTH_BITS;

    // No reset: contents are only ever observed after being written.
    logic [PAYLOAD_BITS-1:0] r_mem [0:c_depth-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : user_stream_buffer_mem
`default_nettype wire

// File: rtl/user_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : user_stream_buffer
// Description : Elastic first-word-fall-through FIFO between a leaf_interface
//               user output port and an HLS kernel ap_vld/ap_ack stream input.
//   clk_user     in   user clock
//   reset        in   asynchronous active-high reset
//   din          in   word from leaf_interface
//   din_vld      in   din valid
//   din_ack      out  buffer accepts din this cycle (not full)
//   dout         out  head word to kernel
//   dout_vld     out  head valid (buffer not empty)
//   dout_ack     in   kernel consumes head this cycle
//   count        out  current occupancy
//   max_count    out  occupancy high-water mark (stats build only, else 0)
//   stall_cycles out  cycles with din_vld & !din_ack (stats build only, else 0)
// Build option: define USER_STREAM_BUFFER_STATS_EN to build the statistics
//               registers; otherwise max_count and stall_cycles read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module user_stream_buffer
    import leaf_stream_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int DEPTH_BITS   = DEFAULT_DEPTH_BITS
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    din_vld,
    output logic                    din_ack,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_vld,
    input  logic                    dout_ack,
    output logic [DEPTH_BITS:0]     count,
    output logic [DEPTH_BITS:0]     max_count,
    output logic [31:0]             stall_cycles
);

    localparam int                    c_cnt_w = count_width(DEPTH_BITS);
    localparam logic [c_cnt_w-1:0]    c_full  = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [DEPTH_BITS-1:0]   r_wr_ptr;
    logic [DEPTH_BITS-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic [c_cnt_w-1:0]      w_count_next;
    logic [PAYLOAD_BITS-1:0] w_rd_data;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;

    assign w_full   = (r_count == c_full);
    // Held low during reset so the upstream never sees a spurious accept.
    // Depends only on state and reset, never on dout_ack.
    assign din_ack  = !reset && !w_full;
    assign dout_vld = (r_count != '0);
    assign w_push   = din_vld && din_ack;
    assign w_pop    = dout_vld && dout_ack;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_cnt_w'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            r_count <= w_count_next;
        end
    end

    user_stream_buffer_mem #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .DEPTH_BITS   (DEPTH_BITS)
    ) u_mem (
        .clk     (clk_user),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // Masked when empty so the unwritten RAM never leaks onto dout.
    assign dout  = dout_vld ? w_rd_data : '0;
    assign count = r_count;

`ifdef USER_STREAM_BUFFER_STATS_EN
    logic [c_cnt_w-1:0] r_max_count;
    logic [31:0]        r_stall_cycles;

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            r_max_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_count_next > r_max_count) begin
                r_max_count <= w_count_next;
            end
            if (din_vld && !din_ack && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign max_count    = r_max_count;
    assign stall_cycles = r_stall_cycles;
`else
    assign max_count    = '0;
    assign stall_cycles = '0;
`endif

endmodule : user_stream_buffer
`default_nettype wire

// File: doc/user_stream_buffer.md
# user_stream_buffer

Elastic FIFO placed between one user-side output port of `leaf_interface` and one ap_vld/ap_ack stream input of an HLS kernel in a leaf. It decouples the kernel's stalls from the interface so that the interface keeps draining BFT packets. Both sides use the same valid/acknowledge protocol, with first-word fall-through on the output. One instance is placed per kernel input stream, in the `clk_user` domain.

## Interface
- PAYLOAD_BITS, 32, width of one stream word; matches the leaf payload width.
- DEPTH_BITS, 4, log2 of FIFO depth (default 16 entries); legal range 1..10.

- clk_user  input  1  user clock; the only clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- din  input  PAYLOAD_BITS  word from `leaf_interface` (dout_leaf_interface2user_N).
- din_vld  input  1  din valid.
- din_ack  output  1  buffer accepts din this cycle.
- dout  output  PAYLOAD_BITS  head word to kernel (Input_N_V_V).
- dout_vld  output  1  head valid (Input_N_V_V_ap_vld).
- dout_ack  input  1  kernel consumes head this cycle (Input_N_V_V_ap_ack).
- count  output  DEPTH_BITS+1  current occupancy, 0..2^DEPTH_BITS.
- max_count  output  DEPTH_BITS+1  occupancy high-water mark (stats build only).
- stall_cycles  output  32  cycles with din_vld=1 and din_ack=0 (stats build only).

## Operation
- Push occurs when din_vld && din_ack; pop occurs when dout_vld && dout_ack.
- din_ack = !full, where full = (count == 2^DEPTH_BITS). din_ack is a registered-state function only, with no combinational path from dout_ack.
- dout_vld = (count != 0); dout = mem[rd_ptr] and is held stable while dout_vld=1 and no pop occurs.
- Pointers are DEPTH_BITS wide and wrap modulo depth. count is a separate register: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push when full cannot happen because ack is low. dout_ack while empty is ignored, and count never underflows.
- Push and pop in the same cycle at count=1: the popped word leaves and the new word becomes head next cycle; count stays 1.
- dout_ack high with dout_vld low does not advance rd_ptr.
- Data words pass through unmodified; no reordering or duplication.

## Timing
- Reset values: din_ack=0 while reset is asserted and 1 from the first cycle after deassertion. dout_vld=0, dout=0, count=0, max_count=0, stall_cycles=0. Pointers are 0.
- Latency: a word pushed at edge N appears on dout/dout_vld after edge N; there is no same-cycle bypass when empty.
- Throughput is 1 word/cycle sustained at any occupancy 1..depth-1. At full, a same-cycle pop frees a slot visible on din_ack the next cycle.
- Reset asserted mid-stream discards all contents asynchronously; there is no partial-word state.

## Configuration
- USER_STREAM_BUFFER_STATS_EN defined: max_count updates to max(max_count, next count) every cycle. stall_cycles increments, saturating at 2^32-1, on each din_vld && !din_ack cycle.
- Not defined: the stats registers are not built and max_count and stall_cycles are tied to 0. Ports remain, so the leaf wrapper is identical in both builds.

## Structure
- Shared package `leaf_stream_pkg`: default PAYLOAD_BITS, DEPTH_BITS, and the count/pointer width helper function.
- Sub-module `user_stream_buffer_mem`: 2^DEPTH_BITS x PAYLOAD_BITS storage with a synchronous write port and an asynchronous read port, mapping to distributed RAM.
- Top level holds the pointers, count, handshake logic and optional stats.

## Test plan
- Reset, then push 0x00000001..0x00000010 with dout_ack=0 -> din_ack drops after the 16th push; count=16; dout=0x00000001 held.
- From full, pulse dout_ack for 1 cycle -> dout becomes 0x00000002, count=15, din_ack=1 on the next cycle.
- Continuous din_vld and dout_ack=1 for 100 words with incrementing data -> one word out per cycle after 1-cycle latency, in order, count stays 1.
- Random din_vld/dout_ack (50%) for 10,000 words -> scoreboard matches exactly; count never exceeds 16 or goes below 0.
- Assert reset asynchronously mid-edge with count=7 -> dout_vld=0 and count=0 immediately; the next pushed word 0xDEADBEEF is the first word out.
- STATS_EN build: hold dout_ack=0 with din_vld=1 for 20 cycles after reset -> max_count=16, stall_cycles=4. Non-stats build: both read 0.
